// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// No logic; no latency; no backpressure.
// States, port indices and the default lock-hold limit.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int LOCK_MAX_DEF = 16;

endpackage

// File: rtl/dmem_arb_rr_pick.sv
// Two-way request picker; onehot grant. DMEM_ARB_RR_EN selects round-robin, else port 0 wins.
// Latency: purely combinational.
// Backpressure: none; a port is granted only while it requests.
module dmem_arb_rr_pick
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

`ifndef DMEM_ARB_RR_EN
    logic unused_last;
    assign unused_last = last;
`endif

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11: begin
`ifdef DMEM_ARB_RR_EN
                grant = (last == PORT0) ? 2'b10 : 2'b01;
`else
                grant = 2'b01;
`endif
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with bus locking; contention policy set by DMEM_ARB_RR_EN.
// Latency: accept N, memory command N+1, read data/rvalid N+2; one access per cycle.
// Backpressure: gnt is combinational; a port holds req until granted, the lock owner blocks the other.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic              clk,
    input  logic              SYS_reset,
    input  logic              P0_req,
    input  logic              P1_req,
    input  logic              P0_we,
    input  logic              P1_we,
    input  logic              P0_lock,
    input  logic              P1_lock,
    input  logic [DATA_W-1:0] P0_addr,
    input  logic [DATA_W-1:0] P1_addr,
    input  logic [DATA_W-1:0] P0_wdata,
    input  logic [DATA_W-1:0] P1_wdata,
    output logic              P0_gnt,
    output logic              P1_gnt,
    output logic              P0_rvalid,
    output logic              P1_rvalid,
    output logic [DATA_W-1:0] P0_rdata,
    output logic [DATA_W-1:0] P1_rdata,
    output logic [DATA_W-1:0] DMEM_address,
    output logic [DATA_W-1:0] DMEM_data_in,
    output logic              DMEM_mem_write,
    output logic              DMEM_mem_read,
    input  logic [DATA_W-1:0] DMEM_data_out
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rd_port_q, rd_port_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic [1:0] pick;
    logic       gnt0, gnt1, acc, acc_port, sel_we, sel_lock, own_lock;
    logic [DATA_W-1:0] sel_addr, sel_wdata;

    dmem_arb_rr_pick u_pick (
        .req   ({P1_req, P0_req}),
        .last  (last_q),
        .grant (pick)
    );

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                gnt0 = pick[0];
                gnt1 = pick[1];
            end
            ARB_OWN0: gnt0 = P0_req;
            ARB_OWN1: gnt1 = P1_req;
            default:  ;
        endcase
        if (SYS_reset) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end

        acc       = gnt0 | gnt1;
        acc_port  = gnt1 ? PORT1 : PORT0;
        sel_we    = gnt1 ? P1_we    : P0_we;
        sel_lock  = gnt1 ? P1_lock  : P0_lock;
        sel_addr  = gnt1 ? P1_addr  : P0_addr;
        sel_wdata = gnt1 ? P1_wdata : P0_wdata;
        own_lock  = (state_q == ARB_OWN1) ? P1_lock : P0_lock;

        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        addr_d      = '0;
        wdata_d     = '0;
        rd_port_d   = rd_port_q;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;

        if (acc) begin
            mem_read_d  = ~sel_we;
            mem_write_d = sel_we;
            addr_d      = sel_addr;
            wdata_d     = sel_we ? sel_wdata : '0;
            rd_port_d   = acc_port;
            last_d      = acc_port;
        end

        // Memory read data is only valid during the command cycle; capture it now.
        if (mem_read_q) begin
            if (rd_port_q == PORT1) begin
                rvalid1_d = 1'b1;
                rdata1_d  = DMEM_data_out;
            end else begin
                rvalid0_d = 1'b1;
                rdata0_d  = DMEM_data_out;
            end
        end

        case (state_q)
            ARB_IDLE: begin
                if (acc && sel_lock) begin
                    state_d = (acc_port == PORT1) ? ARB_OWN1 : ARB_OWN0;
                    cnt_d   = '0;
                end
            end
            ARB_OWN0, ARB_OWN1: begin
                cnt_d = cnt_q + 1'b1;
                // The hold limit overrides a still-asserted lock so the other port cannot starve.
                if (cnt_d == CNT_W'(LOCK_MAX)) begin
                    state_d = ARB_IDLE;
                    cnt_d   = '0;
                    last_d  = (state_q == ARB_OWN1) ? PORT1 : PORT0;
                end else if (!own_lock) begin
                    state_d = ARB_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (SYS_reset) begin
            state_q     <= ARB_IDLE;
            cnt_q       <= '0;
            last_q      <= PORT1;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_port_q   <= PORT0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_port_q   <= rd_port_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign P0_gnt         = gnt0;
    assign P1_gnt         = gnt1;
    assign P0_rvalid      = rvalid0_q;
    assign P1_rvalid      = rvalid1_q;
    assign P0_rdata       = rdata0_q;
    assign P1_rdata       = rdata1_q;
    assign DMEM_address   = addr_q;
    assign DMEM_data_in   = wdata_q;
    assign DMEM_mem_write = mem_write_q;
    assign DMEM_mem_read  = mem_read_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural memory (negedge write, combinational read).
// Latency: inputs driven 1 unit after posedge, outputs sampled 7 units after posedge.
// Backpressure: requests are held by the bench until granted.
module tb_dmem_arbiter;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          SYS_reset;
    logic          P0_req, P1_req, P0_we, P1_we, P0_lock, P1_lock;
    logic [DW-1:0] P0_addr, P1_addr, P0_wdata, P1_wdata;
    logic          P0_gnt, P1_gnt, P0_rvalid, P1_rvalid;
    logic [DW-1:0] P0_rdata, P1_rdata;
    logic [DW-1:0] DMEM_address, DMEM_data_in, DMEM_data_out;
    logic          DMEM_mem_write, DMEM_mem_read;

    logic [DW-1:0] mem [0:255];

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_W(DW), .LOCK_MAX(16)) dut (
        .clk            (clk),
        .SYS_reset      (SYS_reset),
        .P0_req         (P0_req),
        .P1_req         (P1_req),
        .P0_we          (P0_we),
        .P1_we          (P1_we),
        .P0_lock        (P0_lock),
        .P1_lock        (P1_lock),
        .P0_addr        (P0_addr),
        .P1_addr        (P1_addr),
        .P0_wdata       (P0_wdata),
        .P1_wdata       (P1_wdata),
        .P0_gnt         (P0_gnt),
        .P1_gnt         (P1_gnt),
        .P0_rvalid      (P0_rvalid),
        .P1_rvalid      (P1_rvalid),
        .P0_rdata       (P0_rdata),
        .P1_rdata       (P1_rdata),
        .DMEM_address   (DMEM_address),
        .DMEM_data_in   (DMEM_data_in),
        .DMEM_mem_write (DMEM_mem_write),
        .DMEM_mem_read  (DMEM_mem_read),
        .DMEM_data_out  (DMEM_data_out)
    );

    assign DMEM_data_out = mem[DMEM_address[7:0]];

    always @(negedge clk) begin
        if (DMEM_mem_write) mem[DMEM_address[7:0]] <= DMEM_data_in;
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        P0_req = 0; P1_req = 0; P0_we = 0; P1_we = 0; P0_lock = 0; P1_lock = 0;
        P0_addr = '0; P1_addr = '0; P0_wdata = '0; P1_wdata = '0;
    endtask

    task automatic do_reset();
        SYS_reset = 1;
        idle_in();
        tick();
        SYS_reset = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int expp [0:7];
        int first_p1;

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h05] = 32'hDEADBEEF;
        mem[8'h20] = 32'hA0A0A0A0;
        mem[8'h21] = 32'hB1B1B1B1;
        mem[8'h30] = 32'h00003030;

        // Reset state, and no grant while reset is held even with requests pending.
        SYS_reset = 1;
        idle_in();
        tick();
        tick();
        P0_req = 1; P1_req = 1;
        #6;
        chk("rst_p0_gnt", P0_gnt, 0);
        chk("rst_p1_gnt", P1_gnt, 0);
        chk("rst_mem_read", DMEM_mem_read, 0);
        chk("rst_mem_write", DMEM_mem_write, 0);
        chk("rst_addr", DMEM_address, 0);
        chk("rst_din", DMEM_data_in, 0);
        chk("rst_rvalid", {P1_rvalid, P0_rvalid}, 0);
        chk("rst_rdata0", P0_rdata, 0);
        chk("rst_rdata1", P1_rdata, 0);
        tick();
        SYS_reset = 0;
        idle_in();

        // Single read from P0: grant, command one cycle later, data two cycles later.
        P0_req = 1; P0_addr = 32'h05;
        #6;
        chk("rd_c0_p0_gnt", P0_gnt, 1);
        chk("rd_c0_p1_gnt", P1_gnt, 0);
        tick();
        idle_in();
        #6;
        chk("rd_c1_mem_read", DMEM_mem_read, 1);
        chk("rd_c1_addr", DMEM_address, 32'h05);
        chk("rd_c1_rvalid", P0_rvalid, 0);
        tick();
        #6;
        chk("rd_c2_rvalid", P0_rvalid, 1);
        chk("rd_c2_rdata", P0_rdata, 32'hDEADBEEF);
        chk("rd_c2_mem_read", DMEM_mem_read, 0);
        chk("rd_c2_addr", DMEM_address, 0);
        tick();
        #6;
        chk("rd_c3_rvalid", P0_rvalid, 0);
        chk("rd_c3_rdata_hold", P0_rdata, 32'hDEADBEEF);
        tick();

        // Contention with no lock: alternation (round-robin) or P0 always (fixed priority).
        do_reset();
        for (int k = 0; k < 8; k++) begin
`ifdef DMEM_ARB_RR_EN
            expp[k] = k % 2;
`else
            expp[k] = 0;
`endif
        end
        for (int k = 0; k < 8; k++) begin
            if (k < 6) begin
                P0_req = 1; P0_addr = 32'h20;
                P1_req = 1; P1_addr = 32'h21;
            end else begin
                idle_in();
            end
            #6;
            if (k < 6) begin
                chk($sformatf("cont_p0_gnt_%0d", k), P0_gnt, (expp[k] == 0) ? 1 : 0);
                chk($sformatf("cont_p1_gnt_%0d", k), P1_gnt, (expp[k] == 1) ? 1 : 0);
            end
            if (k >= 2) begin
                chk($sformatf("cont_rv0_%0d", k), P0_rvalid, (expp[k-2] == 0) ? 1 : 0);
                chk($sformatf("cont_rv1_%0d", k), P1_rvalid, (expp[k-2] == 1) ? 1 : 0);
                if (expp[k-2] == 0) chk($sformatf("cont_rd0_%0d", k), P0_rdata, 32'hA0A0A0A0);
                else                chk($sformatf("cont_rd1_%0d", k), P1_rdata, 32'hB1B1B1B1);
            end
            tick();
        end

        // P1 locked write then unlocking read; P0 is blocked until the lock drops.
        idle_in();
        P1_req = 1; P1_we = 1; P1_lock = 1; P1_addr = 32'h10; P1_wdata = 32'h1234;
        #6;
        chk("lk_c0_p1_gnt", P1_gnt, 1);
        chk("lk_c0_p0_gnt", P0_gnt, 0);
        tick();
        P0_req = 1; P0_addr = 32'h30;
        P1_we = 0; P1_lock = 0; P1_wdata = '0;
        #6;
        chk("lk_c1_p0_gnt", P0_gnt, 0);
        chk("lk_c1_p1_gnt", P1_gnt, 1);
        chk("lk_c1_mem_write", DMEM_mem_write, 1);
        chk("lk_c1_din", DMEM_data_in, 32'h1234);
        chk("lk_c1_addr", DMEM_address, 32'h10);
        tick();
        P1_req = 0;
        #6;
        chk("lk_c2_p0_gnt", P0_gnt, 1);
        chk("lk_c2_mem_read", DMEM_mem_read, 1);
        chk("lk_c2_mem_write", DMEM_mem_write, 0);
        chk("lk_c2_wr_no_rvalid", P1_rvalid, 0);
        tick();
        idle_in();
        #6;
        chk("lk_c3_p1_rvalid", P1_rvalid, 1);
        chk("lk_c3_p1_rdata", P1_rdata, 32'h1234);
        chk("lk_c3_p0_rvalid", P0_rvalid, 0);
        tick();
        #6;
        chk("lk_c4_p0_rvalid", P0_rvalid, 1);
        chk("lk_c4_p0_rdata", P0_rdata, 32'h00003030);
        tick();

        // P0 takes a lock and keeps lock=1 for 20 cycles; the hold limit releases it to P1.
        P0_req = 1; P0_addr = 32'h05; P0_lock = 1;
        #6;
        chk("lm_c0_p0_gnt", P0_gnt, 1);
        tick();
        P0_req = 0;
        P1_req = 1; P1_addr = 32'h21;
        first_p1 = -1;
        for (int c = 1; c <= 20; c++) begin
            #6;
            if (P1_gnt && first_p1 < 0) first_p1 = c;
            if (P0_gnt) chk($sformatf("lm_p0_gnt_%0d", c), P0_gnt, 0);
            tick();
            if (first_p1 >= 0) P1_req = 0;
        end
        chk("lm_release_cycle", first_p1, 17);
        idle_in();
        tick();
        tick();

        // Reset the cycle after a read acceptance cancels the read.
        P0_req = 1; P0_addr = 32'h05;
        #6;
        chk("rr_c0_p0_gnt", P0_gnt, 1);
        tick();
        SYS_reset = 1;
        P0_req = 1; P1_req = 1;
        #6;
        chk("rr_c1_p0_gnt", P0_gnt, 0);
        chk("rr_c1_p1_gnt", P1_gnt, 0);
        tick();
        SYS_reset = 0;
        idle_in();
        #6;
        chk("rr_c2_rvalid", {P1_rvalid, P0_rvalid}, 0);
        chk("rr_c2_mem_read", DMEM_mem_read, 0);
        chk("rr_c2_mem_write", DMEM_mem_write, 0);
        chk("rr_c2_addr", DMEM_address, 0);
        chk("rr_c2_rdata0", P0_rdata, 0);
        tick();
        #6;
        chk("rr_c3_rvalid", {P1_rvalid, P0_rvalid}, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
